// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver.
//   state_e      : receiver FSM states (2-bit encoding)
//   SYNC_W_DEF   : default sync pattern width
//   SYNC_DEF     : default sync pattern, MSB received first
//   DATA_W_DEF   : default data word width
package serial_frame_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int                      SYNC_W_DEF = 4;
    localparam logic [SYNC_W_DEF-1:0]   SYNC_DEF   = 4'b1011;
    localparam int                      DATA_W_DEF = 8;

endpackage

// File: rtl/sync_matcher.sv
// Sync pattern matcher: a shift window of the last SYNC_W-1 received bits
// plus a comparator against the incoming bit.
//   clk      : clock
//   rst      : synchronous active-high reset (clears the window)
//   clr      : synchronous clear of the window
//   shift_en : shift din into the window this cycle
//   din      : incoming serial bit
//   match    : combinational, {window, din} equals SYNC
module sync_matcher #(
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b1011
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift_en,
    input  logic din,
    output logic match
);

    // Only the newest SYNC_W-1 bits need storing; the current bit completes
    // the comparison window combinationally.
    logic [SYNC_W-2:0] hunt_reg;
    logic [SYNC_W-1:0] window;

    generate
        for (genvar gi = 0; gi < SYNC_W; gi++) begin : g_window
            if (gi == 0) begin : g_lsb
                assign window[gi] = din;
            end else begin : g_hist
                assign window[gi] = hunt_reg[gi-1];
            end
        end
    endgenerate

    assign match = (window == SYNC);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hunt_reg <= '0;
        end else if (shift_en) begin
            hunt_reg <= window[SYNC_W-2:0];
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver. Hunts for a sync pattern on din, shifts in a
// DATA_W-bit word MSB-first, then checks one even-parity bit.
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset
//   din   : serial bit, one per clock (negedge-registered upstream)
//   dout  : last word received with good parity
//   valid : one-cycle pulse, dout updated with a good word
//   err   : one-cycle pulse, parity mismatch, frame dropped
//   busy  : high while inside a frame (DATA or PARITY)
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int                SYNC_W = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC   = SYNC_DEF,
    parameter int                DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              err,
    output logic              busy
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] ST_HUNT   = 2'(HUNT);
    localparam logic [1:0] ST_DATA   = 2'(DATA);
    localparam logic [1:0] ST_PARITY = 2'(PARITY);

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] shreg_reg, shreg_next;
    logic [DATA_W-1:0] dout_reg, dout_next;
    logic              valid_reg, valid_next;
    logic              err_reg, err_next;
    logic              busy_reg, busy_next;
    logic              match;

    // The window only advances while hunting, so sync-like bit runs inside
    // a frame never disturb it; it is wiped on the parity bit so the next
    // hunt starts from a clean history.
    sync_matcher #(
        .SYNC_W (SYNC_W),
        .SYNC   (SYNC)
    ) u_sync_matcher (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_reg == ST_PARITY),
        .shift_en (state_reg == ST_HUNT),
        .din      (din),
        .match    (match)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shreg_next = shreg_reg;
        dout_next  = dout_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            ST_HUNT: begin
                if (match) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                    shreg_next = '0;
                end
            end
            ST_DATA: begin
                shreg_next = {shreg_reg[DATA_W-2:0], din};
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_PARITY;
                end
            end
            ST_PARITY: begin
                // Even parity: data bits and parity bit XOR to zero.
                if (((^shreg_reg) ^ din) == 1'b0) begin
                    dout_next  = shreg_reg;
                    valid_next = 1'b1;
                end else begin
                    err_next   = 1'b1;
                end
                state_next = ST_HUNT;
            end
            default: begin
                state_next = ST_HUNT;
            end
        endcase

        busy_next = (state_next != ST_HUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_HUNT;
            cnt_reg   <= '0;
            shreg_reg <= '0;
            dout_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shreg_reg <= shreg_next;
            dout_reg  <= dout_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
        end
    end

    assign dout  = dout_reg;
    assign valid = valid_reg;
    assign err   = err_reg;
    assign busy  = busy_reg;

endmodule
